// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement sequencer and its readout.
package tdc_pkg;

  localparam int TAPS            = 64;
  localparam int CODE_W          = $clog2(TAPS);
  localparam int FINE_W          = CODE_W + 1;
  localparam int RESULT_COARSE_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_STOP  = 2'd2,
    HOLD       = 2'd3
  } state_t;

  // An all-ones thermometer wraps the 6-bit count to 0; it really means a full line.
  function automatic logic [FINE_W-1:0] map_fine(input logic [CODE_W-1:0] code);
    if (code == '0) begin
      return FINE_W'(TAPS);
    end
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/tdc_controller_hit_sync.sv
// Three-flop synchronizer for a raw hit line with a single-cycle rising-edge pulse.
module hit_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic ff1;
  logic ff2;
  logic ff3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= raw;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign pulse = ff2 & ~ff3;

endmodule

// File: rtl/tdc_controller.sv
// Measurement sequencer: shares one delay line between start/stop hits and builds
// a coarse+fine result word handed to readout over valid/ready.
module tdc_controller
  import tdc_pkg::*;
#(
  parameter int          COARSE_W = RESULT_COARSE_W,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                start_in,
  input  logic                stop_in,
  output logic                dl_signal,
  output logic                dl_sample,
  input  logic [CODE_W-1:0]   dl_fine_count,
  input  logic                dl_valid,
  output logic                busy,
  output logic [COARSE_W-1:0] result_coarse,
  output logic [FINE_W-1:0]   result_fine_start,
  output logic [FINE_W-1:0]   result_fine_stop,
  output logic                result_timeout,
  output logic                result_err,
  output logic                result_valid,
  input  logic                result_ready
);

  localparam logic [COARSE_W-1:0] LIMIT        = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] MIN_INTERVAL = COARSE_W'(3);

  state_t              state;
  state_t              state_next;
  logic                start_event;
  logic                stop_event;
  logic                dl_sel;
  logic [CODE_W-1:0]   fine_code_q;
  logic                fine_valid_q;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] elapsed;
  logic [FINE_W-1:0]   fine_start;
  logic                err_start;
  logic                stop_accept;
  logic                timeout_hit;

  hit_sync u_start_sync (.clk(clk), .rst(rst), .raw(start_in), .pulse(start_event));
  hit_sync u_stop_sync  (.clk(clk), .rst(rst), .raw(stop_in),  .pulse(stop_event));

  // The line carries the stop channel from the start capture until the next arm.
  assign dl_sel       = (state == WAIT_STOP) || (state == HOLD);
  assign dl_signal    = dl_sel ? stop_in : start_in;
  assign dl_sample    = (state == WAIT_START) || (state == WAIT_STOP);
  assign busy         = (state != IDLE);
  assign result_valid = (state == HOLD);

  // elapsed is the edge distance the result reports if the stop lands this cycle.
  assign elapsed     = coarse + 1'b1;
  assign stop_accept = (state == WAIT_STOP) && stop_event && (elapsed >= MIN_INTERVAL);
  assign timeout_hit = (state == WAIT_STOP) && !stop_accept && (elapsed == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (arm) state_next = WAIT_START;
      WAIT_START: if (start_event) state_next = WAIT_STOP;
      WAIT_STOP:  if (stop_accept || timeout_hit) state_next = HOLD;
      HOLD:       if (result_ready) state_next = arm ? WAIT_START : IDLE;
      default:    state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Fine code is registered alongside ff2, so it reflects the line sampled with ff1's first 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fine_code_q       <= '0;
      fine_valid_q      <= 1'b0;
      coarse            <= '0;
      fine_start        <= '0;
      err_start         <= 1'b0;
      result_coarse     <= '0;
      result_fine_start <= '0;
      result_fine_stop  <= '0;
      result_timeout    <= 1'b0;
      result_err        <= 1'b0;
    end else begin
      fine_code_q  <= dl_fine_count;
      fine_valid_q <= dl_valid;
      if ((state == WAIT_START) && start_event) begin
        fine_start <= map_fine(fine_code_q);
        err_start  <= ~fine_valid_q;
        coarse     <= '0;
      end else if (state == WAIT_STOP) begin
        coarse <= elapsed;
      end
      if (!abort && stop_accept) begin
        result_coarse     <= elapsed;
        result_fine_start <= fine_start;
        result_fine_stop  <= map_fine(fine_code_q);
        result_timeout    <= 1'b0;
        result_err        <= err_start | ~fine_valid_q;
      end else if (!abort && timeout_hit) begin
        result_coarse     <= LIMIT;
        result_fine_start <= fine_start;
        result_fine_stop  <= '0;
        result_timeout    <= 1'b1;
        result_err        <= err_start;
      end
    end
  end

endmodule

// File: tb/tb_tdc_controller.sv
// Scoreboard bench for tdc_controller: directed measurements, handshake, abort and reset.
module tb_tdc_controller;
  import tdc_pkg::*;

  localparam int          CW  = 16;
  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        start_in;
  logic        stop_in;
  logic        dl_signal;
  logic        dl_sample;
  logic [5:0]  dl_fine_count;
  logic        dl_valid;
  logic        busy;
  logic [CW-1:0] result_coarse;
  logic [6:0]  result_fine_start;
  logic [6:0]  result_fine_stop;
  logic        result_timeout;
  logic        result_err;
  logic        result_valid;
  logic        result_ready;

  typedef struct packed {
    logic [CW-1:0] coarse;
    logic [6:0]    fs;
    logic [6:0]    fp;
    logic          tmo;
    logic          err;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  tdc_controller #(.COARSE_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .start_in(start_in), .stop_in(stop_in),
    .dl_signal(dl_signal), .dl_sample(dl_sample),
    .dl_fine_count(dl_fine_count), .dl_valid(dl_valid),
    .busy(busy),
    .result_coarse(result_coarse), .result_fine_start(result_fine_start),
    .result_fine_stop(result_fine_stop), .result_timeout(result_timeout),
    .result_err(result_err), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  function automatic res_t make_res(input int c, input int fs, input int fp, input bit tmo, input bit err);
    res_t r;
    r.coarse = CW'(c);
    r.fs     = 7'(fs);
    r.fp     = 7'(fp);
    r.tmo    = tmo;
    r.err    = err;
    return r;
  endfunction

  // Monitor: compares every completed handshake against the oldest expected result.
  always @(negedge clk) begin
    res_t act;
    res_t expv;
    #2;
    if (!rst && result_valid && result_ready) begin
      act = make_res(int'(result_coarse), int'(result_fine_start), int'(result_fine_stop),
                     result_timeout, result_err);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_result got coarse=%0d fs=%0d fp=%0d tmo=%0b err=%0b",
                 act.coarse, act.fs, act.fp, act.tmo, act.err);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          failures++;
          $display("[TB] FAIL result got coarse=%0d fs=%0d fp=%0d tmo=%0b err=%0b expected coarse=%0d fs=%0d fp=%0d tmo=%0b err=%0b",
                   act.coarse, act.fs, act.fp, act.tmo, act.err,
                   expv.coarse, expv.fs, expv.fp, expv.tmo, expv.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (!result_valid && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (!result_valid) begin
      failures++;
      $display("[TB] FAIL %s result_valid got=0 expected=1 within %0d cycles", name, limit);
    end
  endtask

  // One measurement: start raw edge with code c1, stop raw edge `interval` edges later.
  task automatic apply_stimulus(input logic [5:0] c1, input int interval,
                                input logic [5:0] c2, input logic v2);
    arm_pulse();
    tick(2);
    start_in      = 1'b1;
    dl_fine_count = c1;
    dl_valid      = 1'b1;
    tick(interval);
    if (interval >= 3) begin
      check_output("wait_stop_sample", dl_sample, 1);
      check_output("wait_stop_mux", dl_signal, stop_in);
    end
    stop_in       = 1'b1;
    dl_fine_count = c2;
    dl_valid      = v2;
    tick(2);
    check_output("valid_not_early", result_valid, 0);
    tick(1);
    dl_valid = 1'b1;
  endtask

  task automatic finish_meas(input string name);
    start_in = 1'b0;
    stop_in  = 1'b0;
    wait_valid(150, name);
    tick(1);
    check_output({name, "_idle"}, busy, 0);
    tick(4);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; arm = 1'b0; abort = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    dl_fine_count = '0; dl_valid = 1'b1; result_ready = 1'b1;
    #1 rst = 1'b1;
    tick(2);
    check_output("reset_busy", busy, 0);
    check_output("reset_sample", dl_sample, 0);
    check_output("reset_valid", result_valid, 0);
    check_output("reset_coarse", result_coarse, 0);
    rst = 1'b0;
    tick(2);

    // Normal measurement
    exp_q.push_back(make_res(40, 17, 40, 1'b0, 1'b0));
    apply_stimulus(6'd17, 40, 6'd40, 1'b1);
    finish_meas("normal");

    // Saturated start code
    exp_q.push_back(make_res(10, 64, 5, 1'b0, 1'b0));
    apply_stimulus(6'd0, 10, 6'd5, 1'b1);
    finish_meas("saturated");

    // Minimum interval accepted
    exp_q.push_back(make_res(3, 22, 33, 1'b0, 1'b0));
    apply_stimulus(6'd22, 3, 6'd33, 1'b1);
    finish_meas("min_interval");

    // Stop captured while dl_valid low
    exp_q.push_back(make_res(15, 8, 2, 1'b0, 1'b1));
    apply_stimulus(6'd8, 15, 6'd2, 1'b0);
    finish_meas("stop_err");

    // Early stop is discarded and the measurement times out
    exp_q.push_back(make_res(TMO - 1, 9, 0, 1'b1, 1'b0));
    apply_stimulus(6'd9, 2, 6'd50, 1'b1);
    finish_meas("early_stop");

    // Plain timeout, no stop at all
    exp_q.push_back(make_res(TMO - 1, 20, 0, 1'b1, 1'b0));
    arm_pulse();
    tick(2);
    start_in      = 1'b1;
    dl_fine_count = 6'd20;
    tick(3);
    finish_meas("timeout");

    // Handshake back-pressure, then ready together with arm
    result_ready = 1'b0;
    exp_q.push_back(make_res(7, 5, 12, 1'b0, 1'b0));
    apply_stimulus(6'd5, 7, 6'd12, 1'b1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("hold_valid", result_valid, 1);
      check_output("hold_coarse", result_coarse, 7);
      check_output("hold_fine_stop", result_fine_stop, 12);
      tick(1);
    end
    result_ready = 1'b1;
    arm          = 1'b1;
    tick(1);
    arm = 1'b0;
    check_output("rearm_busy", busy, 1);
    check_output("rearm_sample", dl_sample, 1);
    check_output("rearm_valid", result_valid, 0);
    tick(3);

    // Abort in WAIT_STOP
    start_in      = 1'b1;
    dl_fine_count = 6'd30;
    tick(4);
    check_output("abort_pre_busy", busy, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_sample", dl_sample, 0);
    check_output("abort_valid", result_valid, 0);
    start_in = 1'b0;
    tick(4);

    // Asynchronous reset in WAIT_STOP
    arm_pulse();
    tick(2);
    start_in      = 1'b1;
    dl_fine_count = 6'd11;
    tick(6);
    check_output("pre_reset_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check_output("async_busy", busy, 0);
    check_output("async_sample", dl_sample, 0);
    check_output("async_coarse", result_coarse, 0);
    check_output("async_fine_start", result_fine_start, 0);
    check_output("async_mux", dl_signal, start_in);
    #1 rst = 1'b0;
    tick(2);
    stop_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (result_valid) seen = 1'b1;
    end
    check_output("post_reset_no_result", seen, 0);
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(2);

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
